// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
// Optional macro ALU_MC_MUL_EN adds the iterative shift-add multiplier (op 1000).
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal_op
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;
    logic             r_ill;
    logic             r_valid;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_ill;
    logic             w_is_mul;
    logic             w_accept;
    logic             w_lt;
    logic             w_ltu;

    assign w_sum    = src_a + src_b;
    assign w_diff   = src_a - src_b;
    assign w_lt     = $signed(src_a) < $signed(src_b);
    assign w_ltu    = src_a < src_b;
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_ill = 1'b0;
        case (op)
            4'b0000: w_res = src_a & src_b;
            4'b0001: w_res = src_a | src_b;
            4'b0010: begin
                w_res = w_sum;
                w_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            4'b0011: w_res = src_a ^ src_b;
            4'b0100: w_res = src_a & ~src_b;
            4'b0101: w_res = src_a | ~src_b;
            4'b0110: begin
                w_res = w_diff;
                w_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            4'b0111: w_res = {{(WIDTH-1){1'b0}}, w_lt};
            4'b1001: w_res = {{(WIDTH-1){1'b0}}, w_ltu};
            default: w_ill = 1'b1;
        endcase
    end

`ifdef ALU_MC_MUL_EN
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_acc_nx;
    logic             w_last;

    assign w_is_mul = (op == 4'b1000);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_acc_nx = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (w_accept && w_is_mul) begin
            r_acc    <= '0;
            r_mcand  <= src_a;
            r_mplier <= src_b;
            r_cnt    <= '0;
        end else if (r_state == S_MUL && !abort) begin
            r_acc    <= w_acc_nx;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end
`else
    logic [CNT_W:0] w_unused;

    assign w_is_mul = 1'b0;
    assign w_unused = {abort, {CNT_W{1'b0}}};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept)
                    w_next = w_is_mul ? S_MUL : S_DONE;
                else if (r_state == S_DONE && out_ready)
                    w_next = S_IDLE;
            end
`ifdef ALU_MC_MUL_EN
            S_MUL: begin
                if (abort)       w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == S_IDLE) ||
                   (r_state == S_DONE && out_ready);
    end

    // Result and flags only move on a completion; draining just drops valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_ill    <= 1'b0;
            r_valid  <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_result <= w_res;
            r_zero   <= (w_res == '0);
            r_ovf    <= w_ovf;
            r_ill    <= w_ill;
            r_valid  <= 1'b1;
        end else if (w_accept) begin
            r_valid  <= 1'b0;
`ifdef ALU_MC_MUL_EN
        end else if (r_state == S_MUL && !abort && w_last) begin
            r_result <= w_acc_nx;
            r_zero   <= (w_acc_nx == '0);
            r_ovf    <= 1'b0;
            r_ill    <= 1'b0;
            r_valid  <= 1'b1;
`endif
        end else if (r_state == S_DONE && out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign result     = r_result;
    assign zero       = r_zero;
    assign overflow   = r_ovf;
    assign illegal_op = r_ill;
    assign out_valid  = r_valid;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc.
// MUL scenarios run only when ALU_MC_MUL_EN is defined.
module tb_alu_mc;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal_op;

    int n_checks;
    int n_fail;

    alu_mc #(.WIDTH(32)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .overflow   (overflow),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        in_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
    endtask

    logic [3:0]  t_op  [7];
    logic [31:0] t_a   [7];
    logic [31:0] t_b   [7];
    logic [31:0] t_res [7];
    logic        t_ovf [7];

    initial begin
        int bad;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 4'h0;
        src_a     = '0;
        src_b     = '0;
        abort     = 1'b0;
        out_ready = 1'b0;

        t_op[0] = 4'b0001; t_a[0] = 32'hF000_0000; t_b[0] = 32'h0000_000F;
        t_res[0] = 32'hF000_000F; t_ovf[0] = 1'b0;
        t_op[1] = 4'b0011; t_a[1] = 32'h1234_5678; t_b[1] = 32'hFFFF_FFFF;
        t_res[1] = 32'hEDCB_A987; t_ovf[1] = 1'b0;
        t_op[2] = 4'b0100; t_a[2] = 32'hFF00_FF00; t_b[2] = 32'hF0F0_F0F0;
        t_res[2] = 32'h0F00_0F00; t_ovf[2] = 1'b0;
        t_op[3] = 4'b0101; t_a[3] = 32'h0000_0000; t_b[3] = 32'hFFFF_0000;
        t_res[3] = 32'h0000_FFFF; t_ovf[3] = 1'b0;
        t_op[4] = 4'b0110; t_a[4] = 32'h8000_0000; t_b[4] = 32'h0000_0001;
        t_res[4] = 32'h7FFF_FFFF; t_ovf[4] = 1'b1;
        t_op[5] = 4'b0010; t_a[5] = 32'hFFFF_FFFF; t_b[5] = 32'h0000_0001;
        t_res[5] = 32'h0000_0000; t_ovf[5] = 1'b0;
        t_op[6] = 4'b0111; t_a[6] = 32'h0000_0001; t_b[6] = 32'hFFFF_FFFF;
        t_res[6] = 32'h0000_0000; t_ovf[6] = 1'b0;

        #12;
        check("rst_result", result, 32'h0);
        check("rst_zero", {31'b0, zero}, 32'h1);
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_ovf", {31'b0, overflow}, 32'h0);
        check("rst_ill", {31'b0, illegal_op}, 32'h0);
        check("rst_ready", {31'b0, in_ready}, 32'h1);

        tick();
        rst_n = 1'b1;
        tick();

        drive(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        tick();
        in_valid = 1'b0;
        check("add_valid", {31'b0, out_valid}, 32'h1);
        check("add_result", result, 32'h8000_0000);
        check("add_ovf", {31'b0, overflow}, 32'h1);
        check("add_zero", {31'b0, zero}, 32'h0);
        check("add_hold_ready", {31'b0, in_ready}, 32'h0);

        out_ready = 1'b1;
        drive(4'b0110, 32'd5, 32'd5);
        tick();
        check("sub_result", result, 32'h0);
        check("sub_zero", {31'b0, zero}, 32'h1);
        check("sub_ovf", {31'b0, overflow}, 32'h0);
        check("sub_valid", {31'b0, out_valid}, 32'h1);
        drive(4'b0111, 32'hFFFF_FFFF, 32'h1);
        tick();
        check("slt_result", result, 32'h1);
        check("slt_zero", {31'b0, zero}, 32'h0);
        check("slt_valid", {31'b0, out_valid}, 32'h1);
        drive(4'b1001, 32'hFFFF_FFFF, 32'h1);
        tick();
        check("sltu_result", result, 32'h0);
        check("sltu_zero", {31'b0, zero}, 32'h1);

        for (int i = 0; i < 7; i++) begin
            drive(t_op[i], t_a[i], t_b[i]);
            tick();
            check($sformatf("tbl%0d_result", i), result, t_res[i]);
            check($sformatf("tbl%0d_ovf", i), {31'b0, overflow},
                  {31'b0, t_ovf[i]});
            check($sformatf("tbl%0d_ill", i), {31'b0, illegal_op}, 32'h0);
        end

        in_valid = 1'b0;
        tick();
        check("drain_valid", {31'b0, out_valid}, 32'h0);
        check("drain_keep", result, 32'h0);
        check("drain_ready", {31'b0, in_ready}, 32'h1);

`ifdef ALU_MC_MUL_EN
        out_ready = 1'b0;
        drive(4'b1000, 32'h0001_2345, 32'h0000_0010);
        tick();
        in_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            if (i < 31) tick();
        end
        check("mul_busy_cycles", bad, 0);
        tick();
        check("mul_valid", {31'b0, out_valid}, 32'h1);
        check("mul_result", result, 32'h0012_3450);
        check("mul_zero", {31'b0, zero}, 32'h0);

        out_ready = 1'b1;
        drive(4'b1000, 32'd3, 32'd3);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("mul2_valid_low", {31'b0, out_valid}, 32'h0);
        for (int i = 0; i < 9; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_ready", {31'b0, in_ready}, 32'h1);
        check("abort_result", result, 32'h0012_3450);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid !== 1'b0) bad++;
            tick();
        end
        check("abort_no_valid", bad, 0);
`else
        out_ready = 1'b0;
        drive(4'b1000, 32'h0001_2345, 32'h0000_0010);
        tick();
        in_valid = 1'b0;
        check("mul_ill_valid", {31'b0, out_valid}, 32'h1);
        check("mul_ill_flag", {31'b0, illegal_op}, 32'h1);
        check("mul_ill_result", result, 32'h0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("mul_ill_drain", {31'b0, out_valid}, 32'h0);
`endif

        out_ready = 1'b0;
        drive(4'b1111, 32'h1, 32'h2);
        tick();
        check("ill_result", result, 32'h0);
        check("ill_zero", {31'b0, zero}, 32'h1);
        check("ill_flag", {31'b0, illegal_op}, 32'h1);
        check("ill_valid", {31'b0, out_valid}, 32'h1);
        drive(4'b0010, 32'h1, 32'h1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b1 || result !== 32'h0 ||
                illegal_op !== 1'b1) bad++;
        end
        check("ill_hold", bad, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("ill_drain", {31'b0, out_valid}, 32'h0);

        drive(4'b0010, 32'h1, 32'h2);
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("pre_rst_result", result, 32'h3);

`ifdef ALU_MC_MUL_EN
        drive(4'b1000, 32'h0001_2345, 32'h0000_0010);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_result", result, 32'h0);
        check("arst_zero", {31'b0, zero}, 32'h1);
        check("arst_valid", {31'b0, out_valid}, 32'h0);
        check("arst_ready", {31'b0, in_ready}, 32'h1);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", {31'b0, in_ready}, 32'h1);
        drive(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        tick();
        in_valid = 1'b0;
        check("and_result", result, 32'h00F0_00F0);
        check("and_valid", {31'b0, out_valid}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU, successor to the single-cycle datapath ALU.
- Generalised operand width and a 4-bit op code. Adds signed overflow, an illegal-op flag and an iterative shift-add multiplier.
- Uses valid/ready handshakes on both sides, so the execute stage can stall on multi-cycle ops.
- Sits between operand fetch and writeback in the processor datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.
- CNT_W, $clog2(WIDTH), width of the multiply iteration counter. Derived; do not override.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept an op this cycle.
- op  in  4  operation select.
- src_a  in  WIDTH  operand A.
- src_b  in  WIDTH  operand B.
- abort  in  1  synchronous cancel of an in-flight op.
- out_valid  out  1  result registers are valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow (ADD/SUB only).
- illegal_op  out  1  op code was not a defined operation.

Behaviour:
- Reset (rst_n low, async): state=IDLE; result=0, zero=1, overflow=0, illegal_op=0, out_valid=0; counter and multiplier registers cleared. Reset mid-operation discards all work.
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 A&~B, 0101 A|~B, 0110 SUB (A-B).
  - 0111 SLT (signed A<B, result 1 or 0, zero-extended), 1001 SLTU (unsigned).
  - 1000 MUL: low WIDTH bits of A*B; signedness is irrelevant for the low half.
  - All other codes are illegal.
- Arithmetic: modulo 2^WIDTH.
  - overflow=1 on ADD when A and B have the same sign and the result sign differs.
  - overflow=1 on SUB when A and B signs differ and the result sign differs from A.
  - overflow=0 for all other ops.
- States: IDLE, MUL, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Acceptance = in_valid & in_ready.
- Single-cycle op or illegal op accepted at edge N:
  - result, flags and out_valid are registered at edge N; state=DONE.
  - Latency is 1 cycle: visible in the cycle after acceptance.
  - An illegal op gives result=0, zero=1, illegal_op=1.
- MUL accepted at edge N: state=MUL, acc=0, multiplicand=A, multiplier=B, cnt=0.
  - Each MUL cycle: if multiplier[0], acc+=multiplicand; then multiplicand<<=1, multiplier>>=1, cnt++.
  - After WIDTH iterations, at edge N+WIDTH: result=acc, flags updated, out_valid=1, state=DONE.
  - in_ready=0 throughout MUL.
- DONE: out_valid=1; result and flags are held stable until out_ready.
  - out_ready with no new acceptance -> out_valid=0, state=IDLE, result and flags keep their last values.
  - Simultaneous out_ready and acceptance -> back-to-back. The new single-cycle result replaces the old one at the same edge (out_valid stays 1), or the block enters MUL with out_valid=0.
- abort:
  - In MUL: return to IDLE next edge; out_valid stays 0; result and flags unchanged.
  - In IDLE or DONE: no effect; DONE results are never discarded.
  - abort has priority over completion on the final MUL edge.
- in_valid with in_ready=0 is ignored. The upstream stage must hold its op.
- zero is always consistent with the current result register.

Optional Feature:
- ALU_MC_MUL_EN.
- Defined: MUL (1000) is implemented as described above.
- Undefined:
  - 1000 is treated as illegal (1-cycle, result=0, illegal_op=1).
  - State MUL, the counter and the multiplier registers are not synthesised.
  - abort has no effect.

Test Plan:
- Reset release, then ADD A=0x7FFFFFFF B=0x00000001 -> one cycle later out_valid=1, result=0x80000000, overflow=1, zero=0.
- SUB A=5 B=5, then SLT A=0xFFFFFFFF B=1 with out_ready held high (back-to-back):
  - First result=0, zero=1.
  - Next cycle result=1; SLTU on the same operands gives 0.
- MUL A=0x00012345 B=0x00000010 (ALU_MC_MUL_EN defined):
  - in_ready=0 for 32 cycles.
  - out_valid rises 32 edges after acceptance with result=0x00123450.
- MUL in flight, abort pulsed at iteration 10 -> IDLE next edge, out_valid never rises, in_ready=1; the previous result is unchanged.
- Illegal op 1111 -> result=0, zero=1, illegal_op=1. With out_ready=0 for 5 cycles, out_valid and result stay stable; in_valid is ignored during the hold.
- rst_n asserted mid-MUL at iteration 7 -> outputs go to reset values immediately (asynchronously); after release, in_ready=1 and an AND 0xF0F0F0F0 & 0x0FF00FF0 gives 0x00F000F0.
